// File: rtl/param_proc_core.sv
`default_nettype none
// ============================================================================
// Module  : param_proc_core
// Multi-cycle processor core with parametrised data width, register count and
// PC width. Define PROC_MUL_EN to turn opcode F into MUL (otherwise a NOP).
// Revision: 1.0 - initial release
// ============================================================================
module param_proc_core #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int PC_W     = 10,
    parameter int DADDR_W  = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [PC_W-1:0]    pc,
    output logic               instr_req,
    input  logic [15:0]        instr,
    input  logic               instr_valid,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ack,
    output logic [DATA_W-1:0]  result,
    output logic               zero,
    output logic               negative,
    output logic               carry,
    output logic               overflow,
    output logic               busy,
    output logic               halted
);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_MOV = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_CMP = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hC;
    localparam logic [3:0] OP_LD  = 4'hD;
    localparam logic [3:0] OP_ST  = 4'hE;
`ifdef PROC_MUL_EN
    localparam logic [3:0] OP_MUL = 4'hF;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [15:0]       ir;
    logic [DATA_W-1:0] regs [8];

    logic [1:0] cond;
    logic [3:0] opcode;
    logic [2:0] dst, src1, src2;
    logic [6:0] imm7;

    assign cond   = ir[15:14];
    assign opcode = ir[13:10];
    assign dst    = ir[9:7];
    assign src1   = ir[6:4];
    assign src2   = ir[3:1];
    assign imm7   = ir[6:0];

    function automatic logic reg_ok(input logic [2:0] idx);
        return {29'd0, idx} < 32'(NUM_REGS);
    endfunction

    logic [DATA_W-1:0] a, b;
    assign a = reg_ok(src1) ? regs[src1] : '0;
    assign b = reg_ok(src2) ? regs[src2] : '0;

    logic [DATA_W:0] sum, diff;
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

`ifdef PROC_MUL_EN
    logic [2*DATA_W-1:0] prod;
    assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif

    logic [PC_W-1:0] jmp_target;
    assign jmp_target = PC_W'(imm7);

    logic cond_ok;
    always_comb begin
        cond_ok = 1'b1;
        case (cond)
            2'b01:   cond_ok = zero;
            2'b10:   cond_ok = negative;
            2'b11:   cond_ok = carry;
            default: cond_ok = 1'b1;
        endcase
    end

    logic [DATA_W-1:0] alu;
    logic wr_en, upd_flags, c_nxt, v_nxt, is_mem, is_halt, is_jmp;

    always_comb begin
        alu       = '0;
        wr_en     = 1'b0;
        upd_flags = 1'b0;
        c_nxt     = carry;
        v_nxt     = overflow;
        is_mem    = 1'b0;
        is_halt   = 1'b0;
        is_jmp    = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu = sum[DATA_W-1:0]; wr_en = 1'b1; upd_flags = 1'b1;
                c_nxt = sum[DATA_W];
                v_nxt = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB, OP_CMP: begin
                alu = diff[DATA_W-1:0]; wr_en = (opcode == OP_SUB); upd_flags = 1'b1;
                c_nxt = diff[DATA_W];
                v_nxt = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            OP_AND: begin alu = a & b; wr_en = 1'b1; upd_flags = 1'b1; c_nxt = 1'b0; v_nxt = 1'b0; end
            OP_OR:  begin alu = a | b; wr_en = 1'b1; upd_flags = 1'b1; c_nxt = 1'b0; v_nxt = 1'b0; end
            OP_XOR: begin alu = a ^ b; wr_en = 1'b1; upd_flags = 1'b1; c_nxt = 1'b0; v_nxt = 1'b0; end
            OP_MOV: begin alu = a; wr_en = 1'b1; end
            OP_LDI: begin alu = {{(DATA_W-7){1'b0}}, imm7}; wr_en = 1'b1; end
            OP_SHL: begin alu = a << 1; wr_en = 1'b1; upd_flags = 1'b1; c_nxt = a[DATA_W-1]; end
            OP_SHR: begin alu = a >> 1; wr_en = 1'b1; upd_flags = 1'b1; c_nxt = a[0]; end
            OP_JMP: is_jmp = 1'b1;
            OP_HLT: is_halt = 1'b1;
            OP_LD, OP_ST: is_mem = 1'b1;
`ifdef PROC_MUL_EN
            OP_MUL: begin
                alu = prod[DATA_W-1:0]; wr_en = 1'b1; upd_flags = 1'b1;
                c_nxt = |prod[2*DATA_W-1:DATA_W]; v_nxt = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        instr_req = 1'b0;
        dmem_req  = 1'b0;
        busy      = 1'b1;
        halted    = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                instr_req = 1'b1;
                if (instr_valid) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (!cond_ok)     state_nxt = S_FETCH;
                else if (is_mem)  state_nxt = S_MEM;
                else if (is_halt) state_nxt = S_HALT;
                else              state_nxt = S_FETCH;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                if (dmem_ack) state_nxt = S_FETCH;
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
                if (start) state_nxt = S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Memory address/data are captured in EXEC so they stay stable through wait states.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= '0;
            ir         <= '0;
            result     <= '0;
            zero       <= 1'b0;
            negative   <= 1'b0;
            carry      <= 1'b0;
            overflow   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) pc <= '0;
                end
                S_FETCH: begin
                    if (instr_valid) ir <= instr;
                end
                S_EXEC: begin
                    if (!cond_ok) begin
                        pc <= pc + 1'b1;
                    end else if (is_mem) begin
                        dmem_we    <= (opcode == OP_ST);
                        dmem_addr  <= a[DADDR_W-1:0];
                        dmem_wdata <= b;
                    end else if (is_jmp) begin
                        pc <= jmp_target;
                    end else if (!is_halt) begin
                        pc <= pc + 1'b1;
                        if (wr_en) begin
                            result <= alu;
                            if (reg_ok(dst)) regs[dst] <= alu;
                        end
                        if (upd_flags) begin
                            zero     <= (alu == '0);
                            negative <= alu[DATA_W-1];
                            carry    <= c_nxt;
                            overflow <= v_nxt;
                        end
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        pc      <= pc + 1'b1;
                        dmem_we <= 1'b0;
                        if (!dmem_we) begin
                            result <= dmem_rdata;
                            if (reg_ok(dst)) regs[dst] <= dmem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
